// File: rtl/result_accumulator.sv
// Sums a programmed number of single-precision results in Q(ACC_W-FRAC).FRAC fixed point.
// The total is converted back to IEEE-754 single precision and announced with a one-cycle done.
module result_accumulator #(
    parameter int ACC_W = 64,
    parameter int FRAC  = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [15:0] n_items,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, CONVERT, DONE} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                   state;
    logic [15:0]              remaining;
    logic                     s1_valid;
    logic                     s1_ovf;
    logic signed [ACC_W-1:0]  s1_item;
    logic signed [ACC_W-1:0]  acc;

    // stage 1 decode: float -> signed fixed point
    int                       exp_s;
    logic [ACC_W-1:0]         m_ext;
    logic [ACC_W-1:0]         dec_mag;
    logic signed [ACC_W-1:0]  dec_item;
    logic                     dec_ovf;

    always_comb begin
        dec_mag = '0;
        dec_ovf = 1'b0;
        exp_s   = int'(in_data[30:23]) - 150 + FRAC;
        m_ext   = ACC_W'({1'b1, in_data[22:0]});
        if (in_data[30:23] == 8'hff) begin
            dec_ovf = 1'b1;
        end else if (in_data[30:23] != 8'h00) begin
            if (exp_s >= 0) begin
                // a 24-bit significand shifted by more than ACC_W-25 reaches the sign bit
                if (exp_s > ACC_W - 25) dec_ovf = 1'b1;
                else                    dec_mag = m_ext << exp_s;
            end else if (exp_s > -24) begin
                dec_mag = m_ext >> (-exp_s);
            end
        end
        dec_item = in_data[31] ? -dec_mag : dec_mag;
    end

    // stage 2: saturating add
    logic signed [ACC_W-1:0]  sum;
    logic                     add_ovf;

    always_comb begin
        sum     = acc + s1_item;
        add_ovf = (acc[ACC_W-1] == s1_item[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    end

    // fixed -> float: normalise the magnitude so its leading one sits at the msb
    logic [ACC_W-1:0]         mag_f;
    int                       lead;
    logic [22:0]              mant;
    logic [7:0]               fexp;
    logic [31:0]              flt;

    always_comb begin
        if (acc == ACC_MIN)      mag_f = ACC_MAX;
        else if (acc[ACC_W-1])   mag_f = -acc;
        else                     mag_f = acc;
        lead = 0;
        for (int i = 0; i < ACC_W; i++)
            if (mag_f[i]) lead = i;
        mant = 23'((mag_f << (ACC_W - 1 - lead)) >> (ACC_W - 24));
        fexp = 8'(lead - FRAC + 127);
        flt  = (acc == '0) ? 32'h0 : {acc[ACC_W-1], fexp, mant};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            s1_valid  <= 1'b0;
            s1_ovf    <= 1'b0;
            s1_item   <= '0;
            acc       <= '0;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else if (clk_en) begin
            s1_valid <= (state == ACCUM) && in_valid;
            if ((state == ACCUM) && in_valid) begin
                s1_item <= dec_item;
                s1_ovf  <= dec_ovf;
            end
            if (s1_valid) begin
                acc <= add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
                if (add_ovf || s1_ovf) overflow <= 1'b1;
            end
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    acc       <= '0;
                    overflow  <= 1'b0;
                    remaining <= n_items;
                    busy      <= 1'b1;
                    state     <= (n_items == 16'd0) ? DRAIN : ACCUM;
                end
                ACCUM: if (in_valid) begin
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) state <= DRAIN;
                end
                DRAIN:   state <= CONVERT;
                CONVERT: begin
                    result <= flt;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
